// File: rtl/br_enc_onehot2bin_flow.sv
// Pipelined onehot-to-binary decoder with per-item zero/multihot flags and a saturating error count.
// Latency: exactly Latency (1 or 2) register stages from input handshake to out_valid; 1 item/cycle.
// Backpressure: each stage loads when empty or draining; in_ready is combinational from out_ready.
module br_enc_onehot2bin_flow #(
    parameter int NumValues = 2,
    parameter int BinWidth = (NumValues > 1) ? $clog2(NumValues) : 1,
    parameter int Latency = 1,
    parameter int ErrCountWidth = 8,
    parameter bit EnableAssertFinalNotValid = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NumValues-1:0]     in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [BinWidth-1:0]      out,
    output logic                     out_multihot,
    output logic                     out_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ErrCountWidth-1:0] err_count,
    input  logic                     err_count_clear
);

    // Lower half gets the extra bit for odd widths; the upper half is never empty since NumValues >= 2.
    localparam int LoN = (NumValues + 1) / 2;
    localparam int HiN = NumValues - LoN;
    localparam logic [ErrCountWidth-1:0] ErrMax = '1;

    logic in_accept;
    logic in_zero;
    logic in_multihot;
    logic in_err;

    assign in_accept   = in_valid && in_ready;
    assign in_zero     = (in == '0);
    // Clearing the lowest set bit leaves something behind only if two or more bits were set.
    assign in_multihot = |(in & (in - NumValues'(1)));
    assign in_err      = in_zero || in_multihot;

    if (Latency == 1) begin : g_lat1
        logic [BinWidth-1:0] idx_full;

        // Lowest set bit of the whole vector (scanning downward so the lowest one wins).
        always_comb begin
            idx_full = '0;
            for (int i = NumValues - 1; i >= 0; i--) begin
                if (in[i]) idx_full = BinWidth'(i);
            end
        end

        assign in_ready = !out_valid || out_ready;

        // Single output stage: valid follows the input whenever the stage can load.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid    <= 1'b0;
                out          <= '0;
                out_multihot <= 1'b0;
                out_zero     <= 1'b0;
            end else begin
                if (in_ready) out_valid <= in_valid;
                if (in_accept) begin
                    out          <= idx_full;
                    out_multihot <= in_multihot;
                    out_zero     <= in_zero;
                end
            end
        end
    end else begin : g_lat2
        logic [LoN-1:0]      lo_vec;
        logic [HiN-1:0]      hi_vec;
        logic [BinWidth-1:0] lo_idx;
        logic [BinWidth-1:0] hi_idx;
        logic                a_valid;
        logic                a_lo_any;
        logic                a_lo_mh;
        logic                a_hi_any;
        logic                a_hi_mh;
        logic [BinWidth-1:0] a_lo_idx;
        logic [BinWidth-1:0] a_hi_idx;
        logic                a_ready;
        logic                b_ready;
        logic [BinWidth-1:0] b_idx;

        assign lo_vec = in[LoN-1:0];
        assign hi_vec = in[NumValues-1:LoN];

        // Per-half lowest set bit, local to each half.
        always_comb begin
            lo_idx = '0;
            for (int i = LoN - 1; i >= 0; i--) begin
                if (lo_vec[i]) lo_idx = BinWidth'(i);
            end
            hi_idx = '0;
            for (int i = HiN - 1; i >= 0; i--) begin
                if (hi_vec[i]) hi_idx = BinWidth'(i);
            end
        end

        assign b_ready  = !out_valid || out_ready;
        assign a_ready  = !a_valid || b_ready;
        assign in_ready = a_ready;

        // Stage A: register any-set, multihot and local lowest index for each half.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_valid  <= 1'b0;
                a_lo_any <= 1'b0;
                a_lo_mh  <= 1'b0;
                a_hi_any <= 1'b0;
                a_hi_mh  <= 1'b0;
                a_lo_idx <= '0;
                a_hi_idx <= '0;
            end else begin
                if (a_ready) a_valid <= in_valid;
                if (in_accept) begin
                    a_lo_any <= |lo_vec;
                    a_lo_mh  <= |(lo_vec & (lo_vec - LoN'(1)));
                    a_hi_any <= |hi_vec;
                    a_hi_mh  <= |(hi_vec & (hi_vec - HiN'(1)));
                    a_lo_idx <= lo_idx;
                    a_hi_idx <= hi_idx;
                end
            end
        end

        // Combine halves: the lower half owns the index whenever it has any bit set.
        always_comb begin
            b_idx = '0;
            if (a_lo_any)      b_idx = a_lo_idx;
            else if (a_hi_any) b_idx = a_hi_idx + BinWidth'(LoN);
        end

        // Stage B: final index and flags, held while downstream stalls.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid    <= 1'b0;
                out          <= '0;
                out_multihot <= 1'b0;
                out_zero     <= 1'b0;
            end else begin
                if (b_ready) out_valid <= a_valid;
                if (b_ready && a_valid) begin
                    out          <= b_idx;
                    out_multihot <= a_lo_mh || a_hi_mh || (a_lo_any && a_hi_any);
                    out_zero     <= !a_lo_any && !a_hi_any;
                end
            end
        end
    end

    // Error count tracks accepted inputs; a clear wins but still counts an error in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_count_clear) begin
            err_count <= (in_accept && in_err) ? ErrCountWidth'(1) : '0;
        end else if (in_accept && in_err && (err_count != ErrMax)) begin
            err_count <= err_count + ErrCountWidth'(1);
        end
    end

    // Upstream must hold a stalled request steady until it is taken.
    a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid && !in_ready |=> in_valid && $stable(in));

    // A stalled result must not change underneath the consumer.
    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid && $stable(out)
                                    && $stable(out_multihot) && $stable(out_zero));

    a_out_range: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_zero |-> int'(out) < NumValues);

    a_flags_excl: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> !(out_multihot && out_zero));

    // Nothing should be left in flight when simulation ends.
    final begin
        if (EnableAssertFinalNotValid) begin
            a_final_in: assert (!in_valid);
            a_final_out: assert (!out_valid);
        end
    end

endmodule

// File: tb/tb_br_enc_onehot2bin_flow.sv
// Bench for br_enc_onehot2bin_flow: a 5-wide Latency=1 instance and an 8-wide Latency=2 instance
// with a 2-bit error counter, exercised one at a time through shared stimulus signals.
// Expected values come from tables and a queue-based reference model.
module tb_br_enc_onehot2bin_flow;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] din = '0;
    logic       vld = 1'b0;
    logic       ord = 1'b1;
    logic       clr = 1'b0;
    int         sel = 0;

    // Instance A: NumValues=5, Latency=1, ErrCountWidth=8
    logic [4:0] in_a;
    logic       iv_a, ir_a, mh_a, z_a, ov_a, clr_a;
    logic [2:0] out_a;
    logic [7:0] ec_a;
    // Instance B: NumValues=8, Latency=2, ErrCountWidth=2
    logic [7:0] in_b;
    logic       iv_b, ir_b, mh_b, z_b, ov_b, clr_b;
    logic [2:0] out_b;
    logic [1:0] ec_b;

    assign in_a  = din[4:0];
    assign in_b  = din;
    assign iv_a  = vld && (sel == 0);
    assign iv_b  = vld && (sel == 1);
    assign clr_a = clr && (sel == 0);
    assign clr_b = clr && (sel == 1);

    br_enc_onehot2bin_flow #(.NumValues(5), .Latency(1), .ErrCountWidth(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in(in_a), .in_valid(iv_a), .in_ready(ir_a),
        .out(out_a), .out_multihot(mh_a), .out_zero(z_a), .out_valid(ov_a),
        .out_ready(ord), .err_count(ec_a), .err_count_clear(clr_a));

    br_enc_onehot2bin_flow #(.NumValues(8), .Latency(2), .ErrCountWidth(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in_b), .in_valid(iv_b), .in_ready(ir_b),
        .out(out_b), .out_multihot(mh_b), .out_zero(z_b), .out_valid(ov_b),
        .out_ready(ord), .err_count(ec_b), .err_count_clear(clr_b));

    logic       c_ir, c_mh, c_z, c_ov;
    logic [2:0] c_out;
    logic [7:0] c_ec;
    assign c_ir  = sel ? ir_b  : ir_a;
    assign c_mh  = sel ? mh_b  : mh_a;
    assign c_z   = sel ? z_b   : z_a;
    assign c_ov  = sel ? ov_b  : ov_a;
    assign c_out = sel ? out_b : out_a;
    assign c_ec  = sel ? {6'b0, ec_b} : ec_a;

    typedef struct { logic [2:0] idx; bit mh; bit z; } exp_t;
    typedef struct { int s; logic [7:0] v; int idx; bit mh; bit z; } vec_t;

    exp_t q[$];
    int   mcnt[2];
    int   total = 0;
    int   passed = 0;
    bit   acc_now = 0;
    bit   ofire_now = 0;
    logic [2:0] o_out;
    bit   o_mh, o_z;

    function automatic int lat_of(input int s);
        return s ? 2 : 1;
    endfunction

    function automatic int max_of(input int s);
        return s ? 3 : 255;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else passed++;
    endtask

    // Reference decode: isolate the lowest set bit arithmetically and count the ones below it.
    function automatic exp_t ref_dec(input logic [7:0] v);
        exp_t e;
        logic [7:0] low;
        e.z  = (v == 8'd0);
        e.mh = ($countones(v) > 1);
        low  = v & (~v + 8'd1);
        e.idx = e.z ? 3'd0 : 3'($countones(low - 8'd1));
        return e;
    endfunction

    // One clock: sample and score at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e, ni;
        bit   err;
        @(negedge clk);
        chk("err_count", c_ec, mcnt[sel]);
        ofire_now = c_ov && ord;
        acc_now   = vld && c_ir;
        o_out = c_out; o_mh = c_mh; o_z = c_z;
        if (c_ov) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", c_ov, 0);
            end else begin
                e = q[0];
                chk("out_idx", c_out, e.idx);
                chk("out_multihot", c_mh, e.mh);
                chk("out_zero", c_z, e.z);
                if (ord) void'(q.pop_front());
            end
        end
        if (vld && ord) chk("in_ready_full_rate", c_ir, 1);
        ni  = ref_dec(din);
        err = ni.z || ni.mh;
        if (acc_now) q.push_back(ni);
        if (clr) mcnt[sel] = (acc_now && err) ? 1 : 0;
        else if (acc_now && err && mcnt[sel] < max_of(sel)) mcnt[sel]++;
        @(posedge clk);
        #1;
    endtask

    // Send one item with out_ready high and check it emerges exactly Latency cycles later.
    task automatic send_one(input logic [7:0] v, input int idx, input bit mh, input bit z);
        int n;
        ord = 1'b1; vld = 1'b1; din = v; n = 0;
        do begin step(); n++; end while (!acc_now && n < 20);
        chk("accept", acc_now, 1);
        vld = 1'b0; n = 0;
        do begin step(); n++; end while (!ofire_now && n < 20);
        chk("latency", n, lat_of(sel));
        chk("tbl_idx", o_out, idx);
        chk("tbl_multihot", o_mh, mh);
        chk("tbl_zero", o_z, z);
    endtask

    // Finish any pending input, then empty the pipeline.
    task automatic drain();
        int n;
        ord = 1'b1; clr = 1'b0;
        vld = vld && !acc_now;
        n = 0;
        while ((vld || q.size() != 0) && n < 40) begin
            step();
            if (acc_now) vld = 1'b0;
            n++;
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_idle", c_ov, 0);
    endtask

    vec_t       tbl[14];
    logic [7:0] seq[5];
    int         se[5];
    int         k, n;
    logic [7:0] mask;

    initial begin
        tbl[0]  = '{0, 8'b00001, 0, 0, 0};
        tbl[1]  = '{0, 8'b00100, 2, 0, 0};
        tbl[2]  = '{0, 8'b10000, 4, 0, 0};
        tbl[3]  = '{0, 8'b00000, 0, 0, 1};
        tbl[4]  = '{0, 8'b00110, 1, 1, 0};
        tbl[5]  = '{0, 8'b11111, 0, 1, 0};
        tbl[6]  = '{1, 8'b00000000, 0, 0, 1};
        tbl[7]  = '{1, 8'b10010000, 4, 1, 0};
        tbl[8]  = '{1, 8'b10000000, 7, 0, 0};
        tbl[9]  = '{1, 8'b00010000, 4, 0, 0};
        tbl[10] = '{1, 8'b00001000, 3, 0, 0};
        tbl[11] = '{1, 8'b11000000, 6, 1, 0};
        tbl[12] = '{1, 8'b00000011, 0, 1, 0};
        tbl[13] = '{1, 8'b00100000, 5, 0, 0};
        mcnt[0] = 0; mcnt[1] = 0;

        // Reset state on both instances
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            chk("rst_out_valid", c_ov, 0);
            chk("rst_err_count", c_ec, 0);
            chk("rst_out", c_out, 0);
            chk("rst_multihot", c_mh, 0);
            chk("rst_zero", c_z, 0);
        end
        sel = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready_a", ir_a, 1);
        chk("post_rst_in_ready_b", ir_b, 1);

        // Table-driven decode with latency check
        for (int i = 0; i < 14; i++) begin
            sel = tbl[i].s;
            send_one(tbl[i].v, tbl[i].idx, tbl[i].mh, tbl[i].z);
        end

        // Back-to-back on the Latency=1 instance: results on consecutive cycles
        sel = 0; ord = 1'b1;
        seq[0] = 8'b00001; seq[1] = 8'b00100; seq[2] = 8'b10000;
        se[0] = 0; se[1] = 2; se[2] = 4;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin vld = 1'b1; din = seq[i]; end
            else vld = 1'b0;
            step();
            chk("b2b_accept", acc_now, (i < 3));
            if (i >= 1 && i <= 3) begin
                chk("b2b_fire", ofire_now, 1);
                chk("b2b_idx", o_out, se[i-1]);
            end
        end
        drain();

        // Backpressure on the Latency=2 instance
        sel = 1; ord = 1'b0;
        seq[0] = 8'h04; seq[1] = 8'h08; seq[2] = 8'h10; seq[3] = 8'h20; seq[4] = 8'h40;
        k = 0; vld = 1'b1; din = seq[0];
        for (int c = 0; c < 5; c++) begin
            step();
            if (acc_now) begin k++; if (k < 5) din = seq[k]; end
        end
        chk("bp_accepts", k, 2);
        chk("bp_in_ready", c_ir, 0);
        chk("bp_out_valid", c_ov, 1);
        chk("bp_hold_idx", c_out, 2);
        ord = 1'b1; n = 0;
        while (k < 5 && n < 20) begin
            step(); n++;
            if (acc_now) begin k++; if (k < 5) din = seq[k]; else vld = 1'b0; end
        end
        chk("bp_all_accepted", k, 5);
        drain();

        // Counter saturation and clear priority (2-bit counter)
        sel = 1; ord = 1'b1; vld = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
        se[0] = 1; se[1] = 2; se[2] = 3; se[3] = 3; se[4] = 3;
        vld = 1'b1; din = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sat_accept", acc_now, 1);
            chk("sat_count", c_ec, se[i]);
        end
        din = 8'h30; clr = 1'b1;
        step();
        chk("clr_err_accept", acc_now, 1);
        chk("clr_with_err", c_ec, 1);
        clr = 1'b0; vld = 1'b0;
        step();
        clr = 1'b1;
        step();
        chk("clr_alone", c_ec, 0);
        clr = 1'b0;
        drain();

        // Asynchronous reset with two items in flight
        sel = 1; ord = 1'b0; vld = 1'b1; din = 8'h00;
        step();
        chk("rst_fill0", acc_now, 1);
        din = 8'h80;
        step();
        chk("rst_fill1", acc_now, 1);
        vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", c_ov, 0);
        chk("async_rst_err_count", c_ec, 0);
        q.delete(); mcnt[0] = 0; mcnt[1] = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_in_ready", c_ir, 1);
        send_one(8'h20, 5, 0, 0);

        // Randomised traffic against the reference model
        for (int s = 0; s < 2; s++) begin
            sel = s;
            mask = s ? 8'hFF : 8'h1F;
            for (int c = 0; c < 400; c++) begin
                if (!(vld && !acc_now)) begin
                    vld = ($urandom_range(0, 3) != 0);
                    if (vld) begin
                        int r, i, j, nv;
                        nv = s ? 8 : 5;
                        r = $urandom_range(0, 9);
                        if (r < 6) din = 8'd1 << $urandom_range(0, nv - 1);
                        else if (r < 7) din = 8'd0;
                        else begin
                            i = $urandom_range(0, nv - 2);
                            j = $urandom_range(i + 1, nv - 1);
                            din = (8'd1 << i) | (8'd1 << j) | (8'($urandom) & mask);
                        end
                    end
                end
                ord = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 39) == 0);
                step();
            end
            drain();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/br_enc_onehot2bin_flow.md
Name: br_enc_onehot2bin_flow

Overview:
Pipelined onehot-to-binary decoder with ready/valid flow control on both sides. It accepts a NumValues-wide onehot vector and produces the 0-based binary index after Latency register stages. Non-onehot inputs (all-zero or multihot) are flagged per transaction and counted in a saturating error counter. It is the decoding counterpart to the binary-to-onehot encoder and is used where onehot grant and select vectors must be converted back to indices across a pipelined, backpressured path.

Parameters:
NumValues, 2, width of onehot input; must be >= 2.
BinWidth, br_math::clamped_clog2(NumValues), output index width; must be >= clamped_clog2(NumValues).
Latency, 1, number of pipeline register stages; legal values are 1 or 2.
ErrCountWidth, 8, width of the saturating error counter; must be >= 1.
EnableAssertFinalNotValid, 1, if 1, assert in_valid and out_valid are both 0 at end of test.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk.
in  input  NumValues  onehot vector.
in_valid  input  1  in is valid.
in_ready  output  1  block accepts in this cycle.
out  output  BinWidth  binary index.
out_multihot  output  1  more than one bit was set in the source vector.
out_zero  output  1  no bit was set in the source vector.
out_valid  output  1  out and flags are valid.
out_ready  input  1  downstream accepts.
err_count  output  ErrCountWidth  saturating count of accepted non-onehot inputs.
err_count_clear  input  1  synchronous clear of err_count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage valids cleared; out_valid=0; err_count=0.
  - Data registers are reset to 0: out=0, out_multihot=0, out_zero=0.
  - in_ready=1 from the first cycle after reset deassertion.
  - Reset mid-transfer drops any in-flight items silently.
- Handshake:
  - An input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
  - Each stage loads when it is empty or draining: stage_ready = !stage_valid || next_ready.
  - in_ready is combinational from out_ready (no skid); there is no combinational path from in_valid to out_valid.
  - in_valid, once asserted, must hold with stable in until accepted (integration assertion).
  - out_valid, once asserted, holds with stable out and flags until accepted (implementation assertion).
- Latency: an accepted input appears on out_valid exactly Latency cycles later when out_ready stays 1.
  - Full throughput is 1 transfer/cycle.
  - Ordering is preserved and there is no drop or duplication.
- Decode:
  - out is the index of the lowest set bit of in.
  - out_multihot = popcount(in) > 1.
  - out_zero = (in == 0); when out_zero=1, out=0.
  - Upper bits of out above clamped_clog2(NumValues) are 0.
- Latency=2 pipelining:
  - Stage 1 registers per-group partial results: the input is split into two halves, and for each half it registers any-set, multihot, and the local lowest index.
  - Stage 2 combines the halves. The lower half wins the index; multihot is set if either half is multihot or both halves are any-set.
- Error counter:
  - err_count increments on each accepted input (input handshake, not output) that is zero or multihot.
  - It saturates at 2^ErrCountWidth-1 and does not wrap.
  - err_count_clear has priority over the current value: clear together with an error-increment gives err_count=1; clear alone gives 0.
- Backpressure with out_ready=0:
  - The pipeline fills, holding at most Latency items.
  - in_ready falls once all stages are valid.
  - Data is held and not overwritten.
- Assertions:
  - Integration: in_valid stability.
  - Implementation: out_valid stability; out < NumValues when !out_zero; out_multihot and out_zero never both 1.

Test Plan:
- NumValues=5, Latency=1, out_ready=1: send in=5'b00001, 00100, 10000 back-to-back -> out=0,2,4 on consecutive cycles starting 1 cycle after acceptance; flags 0; err_count=0.
- NumValues=8, Latency=2: send in=8'b00000000 -> out=0, out_zero=1, err_count=1. Then send 8'b10010000 -> out=4, out_multihot=1, err_count=2. Each appears 2 cycles after its input handshake.
- Latency=2 with out_ready=0 for 5 cycles while in_valid=1 with distinct onehots -> in_ready=0 after 2 accepts; out holds its first value stable. Releasing out_ready drains all items in order with no loss.
- ErrCountWidth=2: send 5 consecutive zero vectors -> err_count goes 1,2,3,3,3 (saturates). Then pulse err_count_clear in the same cycle as an accepted multihot input -> err_count=1.
- Assert rst_n=0 asynchronously between clock edges with 2 items in flight -> out_valid=0 and err_count=0 immediately. After release, in_ready=1 and the next input decodes correctly.
- Randomised: random onehot, zero, and multihot inputs with random in_valid and out_ready -> scoreboard matches lowest-index, flags, and count; throughput reaches 1/cycle whenever out_ready=1.
